// File: rtl/uart_channel_cmd_proc_pkg.sv
// Shared definitions for the UART channel command processor: opcodes,
// FSM states, command byte layout and the frame parity check.
package channel_proc_pkg;

  // Widest frame (payload + parity) the parity helper accepts.
  localparam int unsigned MAX_FRAME_W = 129;

  localparam logic [1:0] OP_SEL = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    WAIT_TX,
    CLEAR
  } state_t;

  // Low byte of a frame payload.
  typedef struct packed {
    logic [1:0] op;
    logic [5:0] arg;
  } cmd_t;

  // Even parity holds when the XOR over payload and parity bit is zero.
  // Zero-extending a narrower frame does not change the result.
  function automatic logic parity_ok(input logic [MAX_FRAME_W-1:0] frame);
    return ~(^frame);
  endfunction

endpackage

// File: rtl/uart_channel_cmd_proc_if.sv
// Frame input and readback handshake between the UART side and the
// channel command processor.
interface uart_channel_cmd_proc_if #(
  parameter int unsigned DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W:0]   rx_frame;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (
    output rx_valid, rx_frame, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_frame, tx_ready,
    output tx_valid, tx_data
  );
endinterface

// File: rtl/uart_channel_cmd_proc_regfile.sv
// Per-channel register file: one write port, a combinational command read
// port and a combinational display read port. Flat index is {ch, reg}.
module channel_regfile #(
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned N_REG  = 16,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned CH_W   = $clog2(N_CH),
  localparam int unsigned REG_W  = $clog2(N_REG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic [CH_W-1:0]   disp_ch,
  input  logic [REG_W-1:0]  disp_reg,
  output logic [DATA_W-1:0] disp_data_c
);

  localparam int unsigned DEPTH = N_CH * N_REG;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage with asynchronous clear of every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[{wr_ch, wr_reg}] <= wr_data;
    end
  end

  assign rd_data_c   = mem[{rd_ch, rd_reg}];
  assign disp_data_c = mem[{disp_ch, disp_reg}];

endmodule

// File: rtl/uart_channel_cmd_proc.sv
// Channel command processor: decodes parity-checked UART frames into
// select / write / read / clear operations on a per-channel register file,
// returns reads over a valid/ready port and drives a debug display pointer.
// Optional macro CMD_TIMEOUT_EN: abandon a pending write after TIMEOUT_CYC
// idle cycles in WAIT_DATA.
module uart_channel_cmd_proc
  import channel_proc_pkg::*;
#(
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned N_REG       = 16,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned ERR_W       = 8,
  parameter  int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned CH_W        = $clog2(N_CH),
  localparam int unsigned REG_W       = $clog2(N_REG)
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_channel_cmd_proc_if.slave  bus,
  input  logic                    btn_step,
  input  logic                    sw_scope,
  output logic [CH_W-1:0]         sel_ch,
  output logic [CH_W-1:0]         disp_ch,
  output logic [REG_W-1:0]        disp_reg,
  output logic [DATA_W-1:0]       disp_data,
  output logic [ERR_W-1:0]        err_cnt,
  output logic                    busy
);

  // Reject parameter sets the datapath cannot represent.
  if (N_CH < 2 || N_CH > 64 || (N_CH & (N_CH - 1)) != 0 ||
      N_REG < 2 || N_REG > 64 || (N_REG & (N_REG - 1)) != 0 ||
      DATA_W < 8 || DATA_W + 1 > MAX_FRAME_W || ERR_W < 1 ||
      TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_channel_cmd_proc: illegal parameter set");
  end

  state_t            state, state_nxt;
  logic [CH_W-1:0]   sel_ch_nxt;
  logic [REG_W-1:0]  addr, addr_nxt;
  logic [REG_W-1:0]  clr_idx, clr_idx_nxt;
  logic              tx_valid_q, tx_valid_nxt;
  logic [DATA_W-1:0] tx_data_q, tx_data_nxt;

  cmd_t              cmd_c;
  logic              good_c;
  logic              bad_c;
  logic              err_c;
  logic              wr_en_c;
  logic [REG_W-1:0]  wr_reg_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] disp_rd_c;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
`endif

  assign cmd_c  = cmd_t'(bus.rx_frame[7:0]);
  assign good_c = bus.rx_valid &&  parity_ok(MAX_FRAME_W'(bus.rx_frame));
  assign bad_c  = bus.rx_valid && !parity_ok(MAX_FRAME_W'(bus.rx_frame));

  channel_regfile #(
    .N_CH   (N_CH),
    .N_REG  (N_REG),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en_c),
    .wr_ch       (sel_ch),
    .wr_reg      (wr_reg_c),
    .wr_data     (wr_data_c),
    .rd_ch       (sel_ch),
    .rd_reg      (REG_W'(cmd_c.arg)),
    .rd_data_c   (rd_data_c),
    .disp_ch     (disp_ch),
    .disp_reg    (disp_reg),
    .disp_data_c (disp_rd_c)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command decode, next state, datapath updates and regfile write port.
  always_comb begin
    state_nxt    = state;
    sel_ch_nxt   = sel_ch;
    addr_nxt     = addr;
    clr_idx_nxt  = clr_idx;
    tx_valid_nxt = tx_valid_q;
    tx_data_nxt  = tx_data_q;
    err_c        = bad_c;
    wr_en_c      = 1'b0;
    wr_reg_c     = addr;
    wr_data_c    = bus.rx_frame[DATA_W-1:0];
`ifdef CMD_TIMEOUT_EN
    tmo_cnt_nxt  = '0;
`endif
    unique case (state)
      IDLE: begin
        if (good_c) begin
          case (cmd_c.op)
            OP_SEL: begin
              if (32'(cmd_c.arg) < N_CH) sel_ch_nxt = CH_W'(cmd_c.arg);
              else                       err_c      = 1'b1;
            end
            OP_WR: begin
              if (32'(cmd_c.arg) < N_REG) begin
                addr_nxt  = REG_W'(cmd_c.arg);
                state_nxt = WAIT_DATA;
              end else begin
                err_c = 1'b1;
              end
            end
            OP_RD: begin
              if (32'(cmd_c.arg) < N_REG) begin
                tx_data_nxt  = rd_data_c;
                tx_valid_nxt = 1'b1;
                state_nxt    = WAIT_TX;
              end else begin
                err_c = 1'b1;
              end
            end
            OP_CLR: begin
              clr_idx_nxt = '0;
              state_nxt   = CLEAR;
            end
            default: ;
          endcase
        end
      end
      WAIT_DATA: begin
        if (good_c) begin
          wr_en_c   = 1'b1;
          state_nxt = IDLE;
        end
`ifdef CMD_TIMEOUT_EN
        else if (!bus.rx_valid) begin
          if (32'(tmo_cnt) == TIMEOUT_CYC - 1) begin
            err_c     = 1'b1;
            state_nxt = IDLE;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
        end
`endif
      end
      WAIT_TX: begin
        if (good_c) err_c = 1'b1;
        if (bus.tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end
      CLEAR: begin
        if (good_c) err_c = 1'b1;
        wr_en_c     = 1'b1;
        wr_reg_c    = clr_idx;
        wr_data_c   = '0;
        clr_idx_nxt = clr_idx + 1'b1;
        if (32'(clr_idx) == N_REG - 1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command datapath registers, saturating error counter and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_ch     <= '0;
      addr       <= '0;
      clr_idx    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_cnt    <= '0;
      busy       <= 1'b0;
    end else begin
      sel_ch     <= sel_ch_nxt;
      addr       <= addr_nxt;
      clr_idx    <= clr_idx_nxt;
      tx_valid_q <= tx_valid_nxt;
      tx_data_q  <= tx_data_nxt;
      busy       <= (state_nxt != IDLE);
      if (err_c && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Idle-cycle counter for a pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
    end
  end
`endif

  // Display pointer stepping and registered readout of the pointed entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_ch   <= '0;
      disp_reg  <= '0;
      disp_data <= '0;
    end else begin
      if (btn_step) begin
        if (sw_scope) disp_ch  <= disp_ch + 1'b1;
        else          disp_reg <= disp_reg + 1'b1;
      end
      disp_data <= disp_rd_c;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_channel_cmd_proc.sv
// Directed bench for uart_channel_cmd_proc with a readback scoreboard.
module tb_uart_channel_cmd_proc;

  localparam int unsigned N_CH        = 4;
  localparam int unsigned N_REG       = 16;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ERR_W       = 4;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_step;
  logic       sw_scope;
  logic [1:0] sel_ch;
  logic [1:0] disp_ch;
  logic [3:0] disp_reg;
  logic [7:0] disp_data;
  logic [3:0] err_cnt;
  logic       busy;

  uart_channel_cmd_proc_if #(.DATA_W(DATA_W)) bus ();

  uart_channel_cmd_proc #(
    .N_CH        (N_CH),
    .N_REG       (N_REG),
    .DATA_W      (DATA_W),
    .ERR_W       (ERR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .btn_step  (btn_step),
    .sw_scope  (sw_scope),
    .sel_ch    (sel_ch),
    .disp_ch   (disp_ch),
    .disp_reg  (disp_reg),
    .disp_data (disp_data),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         exp_sel;
  int         exp_err;
  logic [7:0] model [N_CH][N_REG];
  logic [7:0] tx_q [$];

  function automatic logic [8:0] mk(input logic [7:0] p);
    return {^p, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < N_CH; c++)
      for (int r = 0; r < N_REG; r++)
        model[c][r] = 8'h00;
  endtask

  task automatic send(input logic [8:0] f);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_frame = f;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_frame = '0;
  endtask

  task automatic sel(input int ch);
    send(mk(8'(ch)));
    exp_sel = ch;
    chk("sel_ch", 32'(sel_ch), 32'(exp_sel));
  endtask

  task automatic wr(input logic [3:0] r, input logic [7:0] d);
    send(mk({4'b0100, r}));
    chk("wr_wait_busy", 32'(busy), 1);
    send(mk(d));
    chk("wr_done_busy", 32'(busy), 0);
    model[exp_sel][r] = d;
  endtask

  task automatic rd(input logic [3:0] r, input int hold);
    tx_q.push_back(model[exp_sel][r]);
    bus.tx_ready = 1'b0;
    send(mk({4'b1000, r}));
    chk("rd_valid", 32'(bus.tx_valid), 1);
    chk("rd_busy", 32'(busy), 1);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk("rd_hold", 32'(bus.tx_valid), 1);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("rd_drop", 32'(bus.tx_valid), 0);
    chk("rd_idle", 32'(busy), 0);
    chk("rd_consumed", 32'(tx_q.size()), 0);
  endtask

  task automatic pulse(input logic scope);
    sw_scope = scope;
    @(posedge clk); #1;
    btn_step = 1'b1;
    @(posedge clk); #1;
    btn_step = 1'b0;
  endtask

  // Readback monitor: every cycle with tx_valid must present the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.tx_valid === 1'b1) begin
      if (tx_q.size() == 0) begin
        chk("tx_unexpected", 32'(tx_q.size()), 1);
      end else begin
        chk("tx_data", 32'(bus.tx_data), 32'(tx_q[0]));
        if (bus.tx_ready) void'(tx_q.pop_front());
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_frame = '0;
    bus.tx_ready = 1'b1;
    btn_step     = 1'b0;
    sw_scope     = 1'b0;
    exp_sel      = 0;
    exp_err      = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_sel_ch", 32'(sel_ch), 0);
    chk("rst_disp_ch", 32'(disp_ch), 0);
    chk("rst_disp_reg", 32'(disp_reg), 0);
    chk("rst_disp_data", 32'(disp_data), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);

    // Select, write and read back with a stalled consumer.
    sel(1);
    chk("sel_err", 32'(err_cnt), 0);
    wr(4'd5, 8'hA5);
    rd(4'd5, 5);
    wr(4'd0, 8'h3C);
    rd(4'd0, 0);
    sel(2);
    wr(4'd15, 8'h5A);
    rd(4'd15, 1);
    sel(3);
    wr(4'd0, 8'h81);
    rd(4'd0, 2);
    sel(1);
    rd(4'd5, 0);

    // Error paths: parity, out-of-range select/write/read arguments.
    send(mk(8'h02) ^ 9'h100);
    exp_err++;
    chk("parity_err", 32'(err_cnt), 32'(exp_err));
    chk("parity_sel_kept", 32'(sel_ch), 32'(exp_sel));
    send(mk(8'h05));
    exp_err++;
    chk("sel5_err", 32'(err_cnt), 32'(exp_err));
    chk("sel5_kept", 32'(sel_ch), 32'(exp_sel));
    send(mk(8'h04));
    exp_err++;
    chk("sel4_err", 32'(err_cnt), 32'(exp_err));
    chk("sel4_kept", 32'(sel_ch), 32'(exp_sel));
    send(mk(8'h50));
    exp_err++;
    chk("wr16_err", 32'(err_cnt), 32'(exp_err));
    chk("wr16_idle", 32'(busy), 0);
    send(mk(8'h90));
    exp_err++;
    chk("rd16_err", 32'(err_cnt), 32'(exp_err));
    chk("rd16_no_tx", 32'(bus.tx_valid), 0);
    chk("rd16_idle", 32'(busy), 0);

    // Display pointer walks and wraps.
    for (int i = 1; i <= 16; i++) begin
      pulse(1'b0);
      chk("disp_reg_step", 32'(disp_reg), 32'(i % 16));
    end
    chk("disp_ch_still", 32'(disp_ch), 0);
    for (int i = 1; i <= 4; i++) begin
      pulse(1'b1);
      chk("disp_ch_step", 32'(disp_ch), 32'(i % 4));
    end
    pulse(1'b1);
    for (int i = 0; i < 5; i++) pulse(1'b0);
    chk("disp_ptr_ch", 32'(disp_ch), 1);
    chk("disp_ptr_reg", 32'(disp_reg), 5);
    chk("disp_data_lag", 32'(disp_data), 32'(model[1][4]));
    @(posedge clk); #1;
    chk("disp_data_1_5", 32'(disp_data), 32'(model[1][5]));

    // Write to the displayed entry shows up one cycle after the commit.
    wr(4'd5, 8'h77);
    chk("disp_before_upd", 32'(disp_data), 32'hA5);
    @(posedge clk); #1;
    chk("disp_after_upd", 32'(disp_data), 32'h77);

    // Button step concurrent with a select command.
    sw_scope = 1'b0;
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_frame = mk(8'h00);
    btn_step     = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    btn_step     = 1'b0;
    exp_sel      = 0;
    chk("concurrent_sel", 32'(sel_ch), 0);
    chk("concurrent_disp", 32'(disp_reg), 6);
    sel(1);
    wr(4'd6, 8'h66);
    @(posedge clk); #1;
    chk("disp_1_6", 32'(disp_data), 32'h66);

    // Clear channel 1 with an overrunning frame mid-clear.
    send(mk(8'hC0));
    chk("clr_busy", 32'(busy), 1);
    repeat (2) @(posedge clk);
    #1;
    send(mk(8'h02));
    exp_err++;
    chk("clr_overrun_err", 32'(err_cnt), 32'(exp_err));
    chk("clr_overrun_sel", 32'(sel_ch), 1);
    repeat (11) @(posedge clk);
    #1;
    chk("clr_busy_15", 32'(busy), 1);
    @(posedge clk); #1;
    chk("clr_done_16", 32'(busy), 0);
    for (int r = 0; r < N_REG; r++) model[1][r] = 8'h00;
    @(posedge clk); #1;
    chk("clr_disp_zero", 32'(disp_data), 0);
    rd(4'd5, 0);
    rd(4'd15, 2);
    rd(4'd0, 0);
    sel(2);
    rd(4'd15, 0);

    // Error counter saturates.
    for (int i = 0; i < 12; i++) begin
      send(mk(8'h01) ^ 9'h100);
      exp_err = (exp_err < 15) ? exp_err + 1 : 15;
      chk("err_sat", 32'(err_cnt), 32'(exp_err));
    end

    // Reset in the middle of a pending readback.
    tx_q.push_back(model[2][15]);
    bus.tx_ready = 1'b0;
    send(mk(8'h8F));
    chk("pre_rst_valid", 32'(bus.tx_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.tx_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err_cnt), 0);
    chk("mid_rst_sel", 32'(sel_ch), 0);
    tx_q.delete();
    clear_model();
    exp_sel = 0;
    exp_err = 0;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(bus.tx_valid), 0);
    chk("post_rst_disp", 32'(disp_data), 0);
    sel(2);
    rd(4'd15, 0);

`ifdef CMD_TIMEOUT_EN
    // Pending write abandoned after the timeout; later frame is a command.
    sel(1);
    wr(4'd5, 8'hA5);
    send(mk(8'h45));
    chk("tmo_wait_busy", 32'(busy), 1);
    repeat (63) @(posedge clk);
    #1;
    chk("tmo_busy_63", 32'(busy), 1);
    @(posedge clk); #1;
    chk("tmo_idle_64", 32'(busy), 0);
    exp_err++;
    chk("tmo_err", 32'(err_cnt), 32'(exp_err));
    send(mk(8'hA5));
    exp_err++;
    chk("tmo_cmd_err", 32'(err_cnt), 32'(exp_err));
    chk("tmo_cmd_no_tx", 32'(bus.tx_valid), 0);
    chk("tmo_cmd_idle", 32'(busy), 0);
    rd(4'd5, 0);
`else
    // Pending write waits indefinitely for its data frame.
    sel(1);
    send(mk(8'h45));
    repeat (100) @(posedge clk);
    #1;
    chk("wait_busy", 32'(busy), 1);
    send(mk(8'h11));
    chk("wait_done", 32'(busy), 0);
    model[1][5] = 8'h11;
    chk("wait_err", 32'(err_cnt), 0);
    rd(4'd5, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
